// File: rtl/mac_row_feeder_pkg.sv
// mac_row_feeder_pkg
//   Shared constants for the systolic row west-edge feeder: the inst_w
//   encoding driven into the PE row and the feeder phase encoding. The
//   south-side collector and the testbench import the same definitions.
package mac_row_feeder_pkg;

    // inst_w encoding seen by every PE: bit 1 = execute, bit 0 = kernel load
    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    // Width of the optional stall statistics counter
    localparam int STALL_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GAP   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DRAIN = 3'd4
    } feeder_state_e;

    // Phases in which the feeder accepts stream words
    function automatic logic stream_state(input feeder_state_e st);
        return (st == ST_LOAD) || (st == ST_EXEC);
    endfunction

endpackage

// File: rtl/mac_row_feeder_if.sv
// mac_row_feeder_if
//   valid/ready word stream into the row feeder.
//   in_data  : bw-bit word, driven by the source
//   in_valid : word present, driven by the source
//   in_ready : feeder can take the word this cycle
//   master modport = stream source, slave modport = feeder.
interface mac_row_feeder_if #(
    parameter int bw = 4
);
    logic [bw-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mac_row_feeder_stall_counter.sv
// stall_counter
//   Saturating event counter with synchronous clear.
//   clk   : clock
//   reset : synchronous active-low reset
//   clr   : clear to zero (wins over en)
//   en    : count one event this cycle
//   cnt   : registered count, sticks at all-ones
module stall_counter #(
    parameter int w = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [w-1:0] cnt
);

    localparam logic [w-1:0] CNT_ZERO = {w{1'b0}};
    localparam logic [w-1:0] CNT_MAX  = {w{1'b1}};
    localparam logic [w-1:0] CNT_ONE  = w'(1);

    logic [w-1:0] cnt_r;

    // Count enabled events, clear on request, saturate at the maximum
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/mac_row_feeder.sv
// mac_row_feeder
//   West-edge driver for one systolic MAC row. Per job it forwards exactly
//   `col` kernel words (inst 01), one NOP gap cycle, `num_exec` activation
//   words (inst 10), then `col` NOP drain cycles so the last word reaches
//   the far end of the row.
//
// Ports
//   clk       : clock
//   reset     : synchronous active-low reset
//   start     : job request, only looked at in IDLE
//   num_exec  : activation word count, latched on start
//   in_s      : word stream (slave side of mac_row_feeder_if)
//   out_w     : row in_w, registered
//   inst_w    : row inst_w, registered together with out_w
//   busy      : job in progress
//   done      : one-cycle pulse in the first IDLE cycle after a job
//   stall_cnt : (MAC_ROW_FEEDER_STATS_EN only) LOAD/EXEC cycles without a
//               valid word, saturating, cleared on reset and job start
//
// Build option: define MAC_ROW_FEEDER_STATS_EN to add stall_cnt.
module mac_row_feeder
    import mac_row_feeder_pkg::*;
#(
    parameter int bw     = 4,
    parameter int col    = 8,
    parameter int cnt_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [cnt_bw-1:0] num_exec,
    mac_row_feeder_if.slave   in_s,
    output logic [bw-1:0]     out_w,
    output logic [1:0]        inst_w,
    output logic              busy,
    output logic              done
`ifdef MAC_ROW_FEEDER_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    // One down-counter serves both the kernel-load count and the drain length
    localparam int CNT_W = $clog2(col + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_COL   = CNT_W'(col);
    localparam logic [cnt_bw-1:0] EXEC_ZERO = {cnt_bw{1'b0}};
    localparam logic [cnt_bw-1:0] EXEC_ONE  = cnt_bw'(1);
    localparam logic [bw-1:0]     WORD_ZERO = {bw{1'b0}};

    feeder_state_e     st_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [cnt_bw-1:0] exec_left_r;
    logic [bw-1:0]     out_w_r;
    logic [1:0]        inst_w_r;
    logic              in_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              accept_s;

    // in_ready_r is only ever 1 in LOAD/EXEC, so this is the handshake
    assign accept_s = in_s.in_valid & in_ready_r;

    // Job sequencer: phase, counters and all registered outputs. in_ready_r
    // and busy_r are written with the value the next state needs, so they
    // are pure registered decodes of the phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st_r        <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            exec_left_r <= EXEC_ZERO;
            out_w_r     <= WORD_ZERO;
            inst_w_r    <= INST_NOP;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            // Bubble unless a word is forwarded below
            out_w_r  <= WORD_ZERO;
            inst_w_r <= INST_NOP;
            done_r   <= 1'b0;
            case (st_r)
                ST_IDLE: begin
                    if (start) begin
                        exec_left_r <= num_exec;
                        cnt_r       <= CNT_COL;
                        st_r        <= ST_LOAD;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        in_ready_r  <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        out_w_r  <= in_s.in_data;
                        inst_w_r <= INST_LOAD;
                        cnt_r    <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            st_r       <= ST_GAP;
                            in_ready_r <= 1'b0;
                        end else begin
                            in_ready_r <= 1'b1;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (exec_left_r != EXEC_ZERO) begin
                        st_r       <= ST_EXEC;
                        in_ready_r <= 1'b1;
                    end else begin
                        st_r       <= ST_DRAIN;
                        cnt_r      <= CNT_COL;
                        in_ready_r <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (accept_s) begin
                        out_w_r     <= in_s.in_data;
                        inst_w_r    <= INST_EXEC;
                        exec_left_r <= exec_left_r - EXEC_ONE;
                        if (exec_left_r == EXEC_ONE) begin
                            st_r       <= ST_DRAIN;
                            cnt_r      <= CNT_COL;
                            in_ready_r <= 1'b0;
                        end else begin
                            in_ready_r <= 1'b1;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        st_r   <= ST_IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    st_r       <= ST_IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_s.in_ready = in_ready_r;
    assign out_w         = out_w_r;
    assign inst_w        = inst_w_r;
    assign busy          = busy_r;
    assign done          = done_r;

`ifdef MAC_ROW_FEEDER_STATS_EN
    logic stall_en_s;
    logic stall_clr_s;

    assign stall_en_s  = stream_state(st_r) && !in_s.in_valid;
    assign stall_clr_s = (st_r == ST_IDLE) && start;

    stall_counter #(
        .w (STALL_CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (stall_clr_s),
        .en    (stall_en_s),
        .cnt   (stall_cnt)
    );
`endif

endmodule
